// File: rtl/debug_frame_tx.sv
// Debug-link transmitter: returns one header frame plus N data words
// to the host, paced by GOT_DATA / GIB_DATA host commands.
//
// Ports:
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_frame_from_blaze      host command {code,valid,addr_type,address}
//   i_load/_type/_nwords/_data  one-cycle transfer request and payload
//   o_frame_to_blaze        registered frame seen by the host
//   o_busy, o_done          transfer active / last frame acknowledged
module debug_frame_tx #(
  parameter int          NB_CONTROL_FRAME = 32,
  parameter int          MAX_WORDS        = 4,
  parameter int          NB_WCOUNT        = 3,
  parameter logic [5:0]  HDR_CODE         = 6'b1100_00
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic [NB_CONTROL_FRAME-1:0]       i_frame_from_blaze,
  input  logic                              i_load,
  input  logic [8:0]                        i_load_type,
  input  logic [NB_WCOUNT-1:0]              i_load_nwords,
  input  logic [MAX_WORDS*NB_CONTROL_FRAME-1:0] i_load_data,
  output logic [NB_CONTROL_FRAME-1:0]       o_frame_to_blaze,
  output logic                              o_busy,
  output logic                              o_done
);

  localparam logic [5:0] CMD_GOT = 6'b1001_00;
  localparam logic [5:0] CMD_GIB = 6'b1001_01;
  localparam logic [5:0] CMD_RST = 6'b0000_10;

  localparam logic [NB_WCOUNT-1:0] WMAX = NB_WCOUNT'(MAX_WORDS);
  localparam logic [NB_WCOUNT-1:0] WONE = NB_WCOUNT'(1);
  localparam int                   NPAD = 16 - NB_WCOUNT;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_DATA
  } state_t;

  state_t                               state_q, state_d;
  logic [NB_WCOUNT-1:0]                 idx_q, idx_d;
  logic [NB_WCOUNT-1:0]                 nw_q, nw_d;
  logic [8:0]                           type_q, type_d;
  logic [MAX_WORDS*NB_CONTROL_FRAME-1:0] data_q, data_d;
  logic [NB_CONTROL_FRAME-1:0]          frame_q, frame_d;
  logic                                 valid_q;
  logic                                 done_q, done_d;

  logic                                 valid_now;
  logic                                 ev;
  logic [5:0]                           code;
  logic                                 cmd_got;
  logic                                 cmd_gib;
  logic                                 cmd_rst;
  logic [NB_WCOUNT-1:0]                 nw_clamp;
  logic [NB_CONTROL_FRAME-1:0]          word_sel;

  // Address fields of host commands are not needed here.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^i_frame_from_blaze[24:0];

  // Host holds each command for several cycles; act on the rising
  // edge of its valid bit only.
  assign valid_now = i_frame_from_blaze[25];
  assign ev        = valid_now & ~valid_q;
  assign code      = i_frame_from_blaze[31:26];
  assign cmd_got   = ev && (code == CMD_GOT);
  assign cmd_gib   = ev && (code == CMD_GIB);
  assign cmd_rst   = ev && (code == CMD_RST);

  assign nw_clamp = (i_load_nwords > WMAX) ? WMAX : i_load_nwords;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nw_d    = nw_q;
    type_d  = type_q;
    data_d  = data_q;
    done_d  = 1'b0;
    if (cmd_rst) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_load) begin
            state_d = S_HEADER;
            idx_d   = '0;
            nw_d    = nw_clamp;
            type_d  = i_load_type;
            data_d  = i_load_data;
          end
        end
        S_HEADER: begin
          if (cmd_gib) begin
            idx_d = '0;
          end else if (cmd_got) begin
            idx_d = '0;
            if (nw_q == '0) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (cmd_gib) begin
            state_d = S_HEADER;
            idx_d   = '0;
          end else if (cmd_got) begin
            if (idx_q == nw_q - WONE) begin
              state_d = S_IDLE;
              idx_d   = '0;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + WONE;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Constant slices keep the word mux free of out-of-range indexing.
  always_comb begin
    word_sel = '0;
    for (int k = 0; k < MAX_WORDS; k++) begin
      if (idx_d == NB_WCOUNT'(k)) begin
        word_sel = data_d[k*NB_CONTROL_FRAME +: NB_CONTROL_FRAME];
      end
    end
  end

  // Frame is derived from next state so it appears one cycle after
  // the load or command that caused it.
  always_comb begin
    frame_d = '0;
    case (state_d)
      S_HEADER: frame_d = {HDR_CODE, 1'b1, type_d, {NPAD{1'b0}}, nw_d};
      S_DATA:   frame_d = word_sel;
      default:  frame_d = '0;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      nw_q    <= '0;
      type_q  <= '0;
      data_q  <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nw_q    <= nw_d;
      type_q  <= type_d;
      data_q  <= data_d;
      frame_q <= frame_d;
      valid_q <= valid_now;
      done_q  <= done_d;
    end
  end

  assign o_frame_to_blaze = frame_q;
  assign o_busy           = (state_q != S_IDLE);
  assign o_done           = done_q;

endmodule

// File: tb/tb_debug_frame_tx.sv
// Bench for debug_frame_tx: transfer-level model checked every
// cycle, plus directed literal checks of frame values.
module tb_debug_frame_tx;

  localparam logic [5:0] GOT = 6'b1001_00;
  localparam logic [5:0] GIB = 6'b1001_01;
  localparam logic [5:0] RST = 6'b0000_10;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  fin;
  logic         ld;
  logic [8:0]   ltype;
  logic [2:0]   lnw;
  logic [127:0] ldata;
  logic [31:0]  frame;
  logic         busy;
  logic         done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  debug_frame_tx dut (
    .i_clock            (clk),
    .i_reset            (rst),
    .i_frame_from_blaze (fin),
    .i_load             (ld),
    .i_load_type        (ltype),
    .i_load_nwords      (lnw),
    .i_load_data        (ldata),
    .o_frame_to_blaze   (frame),
    .o_busy             (busy),
    .o_done             (done)
  );

  // Transfer model: pos 0 is the header, pos k>0 is data word k-1.
  bit          m_started = 0;
  bit          m_act;
  bit          m_prev;
  int          m_pos;
  int          m_n;
  logic [8:0]  m_type;
  logic [31:0] m_w [4];
  logic [31:0] e_frame;
  logic        e_done;

  always @(posedge clk) begin
    bit ev;
    m_started = 1;
    e_done = 0;
    if (rst) begin
      m_act = 0; m_prev = 0; m_pos = 0;
    end else begin
      ev = fin[25] && !m_prev;
      m_prev = fin[25];
      if (ev && fin[31:26] == RST) begin
        m_act = 0;
      end else if (m_act && ev && fin[31:26] == GIB) begin
        m_pos = 0;
      end else if (m_act && ev && fin[31:26] == GOT) begin
        if (m_pos == m_n) begin
          m_act = 0; e_done = 1;
        end else begin
          m_pos++;
        end
      end else if (!m_act && ld) begin
        m_act = 1; m_pos = 0;
        m_type = ltype;
        m_n = (lnw > 4) ? 4 : int'(lnw);
        for (int k = 0; k < 4; k++) m_w[k] = ldata[32*k +: 32];
      end
    end
    if (!m_act) e_frame = 0;
    else if (m_pos == 0) e_frame = {6'b110000, 1'b1, m_type, 16'(m_n)};
    else e_frame = m_w[m_pos-1];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_started) begin
      chk("mdl_frame", frame, e_frame);
      chk("mdl_busy", 32'(busy), 32'(m_act));
      chk("mdl_done", 32'(done), 32'(e_done));
    end
  end

  // Issue one command held for hold cycles, then drop valid for one.
  // Frame/done are checked after the first edge that sees the command.
  task automatic cmd(input logic [5:0] c, input int hold, input bit with_ld,
                     input logic [31:0] ef, input logic ed, input string nm);
    fin = {c, 1'b1, 9'h0, 16'h0};
    if (with_ld) ld = 1;
    @(negedge clk);
    ld = 0;
    chk(nm, frame, ef);
    chk({nm, "_done"}, 32'(done), 32'(ed));
    repeat (hold - 1) @(negedge clk);
    fin = 0;
    @(negedge clk);
  endtask

  task automatic load(input logic [8:0] t, input logic [2:0] n,
                      input logic [127:0] d);
    ltype = t; lnw = n; ldata = d; ld = 1;
    @(negedge clk);
    ld = 0;
  endtask

  localparam logic [127:0] D3 =
    128'h0000_0000_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;

  initial begin
    rst = 1; fin = 0; ld = 0; ltype = 0; lnw = 0; ldata = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_frame", frame, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Basic 3-word transfer.
    load(9'h020, 3'd3, D3);
    chk("hdr3", frame, 32'hC220_0003);
    chk("hdr3_model", e_frame, 32'hC220_0003);
    chk("hdr3_busy", 32'(busy), 32'h1);
    cmd(GOT, 3, 0, 32'hAAAA_AAAA, 0, "w0");
    cmd(GOT, 3, 0, 32'hBBBB_BBBB, 0, "w1");
    cmd(GOT, 3, 0, 32'hCCCC_CCCC, 0, "w2");
    cmd(GOT, 3, 0, 32'h0, 1, "fin3");
    chk("fin3_busy", 32'(busy), 32'h0);

    // Held command advances once; GIB restarts with same payload.
    load(9'h020, 3'd3, D3);
    cmd(GOT, 5, 0, 32'hAAAA_AAAA, 0, "hold_w0");
    chk("hold_once", frame, 32'hAAAA_AAAA);
    cmd(GOT, 2, 0, 32'hBBBB_BBBB, 0, "hold_w1");
    cmd(6'h3F, 2, 0, 32'hBBBB_BBBB, 0, "ignored");
    cmd(GIB, 2, 0, 32'hC220_0003, 0, "gib_hdr");
    cmd(GOT, 2, 0, 32'hAAAA_AAAA, 0, "gib_w0");

    // Load while busy is ignored; RESET command aborts silently.
    load(9'h1FF, 3'd1, {4{32'h1234_5678}});
    chk("busy_load", frame, 32'hAAAA_AAAA);
    cmd(GOT, 2, 0, 32'hBBBB_BBBB, 0, "busy_w1");
    cmd(RST, 2, 0, 32'h0, 0, "rstcmd");
    chk("rstcmd_busy", 32'(busy), 32'h0);

    // Zero words.
    load(9'h1FF, 3'd0, 128'h0);
    chk("hdr0", frame, 32'hC3FF_0000);
    cmd(GOT, 2, 0, 32'h0, 1, "fin0");

    // Count clamp; load racing the final GOT is ignored.
    load(9'h020, 3'd7, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    chk("hdr_clamp", frame, 32'hC220_0004);
    cmd(GOT, 2, 0, 32'h1111_1111, 0, "c0");
    cmd(GOT, 2, 0, 32'h2222_2222, 0, "c1");
    cmd(GOT, 2, 0, 32'h3333_3333, 0, "c2");
    cmd(GOT, 2, 0, 32'h4444_4444, 0, "c3");
    cmd(GOT, 2, 1, 32'h0, 1, "c_fin");
    chk("race_idle", 32'(busy), 32'h0);

    // Hardware reset in the middle of a transfer.
    load(9'h020, 3'd3, D3);
    cmd(GOT, 2, 0, 32'hAAAA_AAAA, 0, "pre_rst");
    rst = 1;
    repeat (3) @(negedge clk);
    chk("mid_rst_frame", frame, 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    rst = 0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
